axis_pkt_arb_2_1: RTL and testbench
===================================

Name: axis_pkt_arb_2_1

Overview:
- Packet-level round-robin arbiter for two AXI-Stream sources sharing one AXI-Stream sink.
- Contains the 2:1 AXI-Stream mux datapath and the sequencer that drives its select.
- A grant is held for a whole packet, from the first beat through the beat with tlast=1, so packets never interleave.
- Per-source packet counters and grant status are exposed for debug and bench checking.

Parameters:
- DW, 8, tdata width in bits.
- PCW, 16, width of each per-source completed-packet counter.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous active-low reset: sampled on the rising edge of clk, asserted when 0.
- s1_tdata  input  DW  source 1 data.
- s1_tvalid  input  1  source 1 valid.
- s1_tlast  input  1  source 1 end of packet.
- s1_tready  output  1  source 1 ready.
- s2_tdata  input  DW  source 2 data.
- s2_tvalid  input  1  source 2 valid.
- s2_tlast  input  1  source 2 end of packet.
- s2_tready  output  1  source 2 ready.
- m_tdata  output  DW  sink data.
- m_tvalid  output  1  sink valid.
- m_tlast  output  1  sink end of packet.
- m_tready  input  1  sink ready.
- sel  output  1  current grant: 0 = s1, 1 = s2. Meaningful only while busy=1.
- busy  output  1  a packet grant is active.
- s1_pkt_cnt  output  PCW  s1 packets completed.
- s2_pkt_cnt  output  PCW  s2 packets completed.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst=0 at a clk edge):
  - FSM goes to IDLE, busy=0, sel=0.
  - Round-robin pointer last=1, so s1 has priority on the first contention.
  - Both packet counters are cleared to 0.
- Combinational outputs (follow from FSM state):
  - IDLE: s1_tready=0, s2_tready=0, m_tvalid=0, m_tdata=0, m_tlast=0.
  - These values also hold on the cycle after any reset edge.
- State IDLE:
  - Samples s1_tvalid and s2_tvalid.
  - Only s1 valid -> GRANT1. Only s2 valid -> GRANT2.
  - Both valid -> grant the source not equal to last (last=1 gives GRANT1; last=0 gives GRANT2).
  - Neither valid -> stay in IDLE.
  - No beat is transferred in IDLE (one-cycle arbitration bubble per packet).
- State GRANT1 (sel=0, busy=1):
  - m_tdata=s1_tdata, m_tvalid=s1_tvalid, m_tlast=s1_tlast.
  - s1_tready=m_tready, s2_tready=0.
- State GRANT2: mirror of GRANT1 using s2 (sel=1, busy=1).
- Handshake: a beat transfers when m_tvalid and m_tready are both 1 at a clk edge.
  - Zero-cycle latency, pure pass-through; the block adds no buffering.
- Packet end: a transfer with m_tlast=1 in GRANTx causes, at that edge:
  - sx_pkt_cnt increments;
  - last = x (0 for s1, 1 for s2);
  - FSM returns to IDLE.
- Grant holding:
  - Source valid dropping mid-packet does not release the grant; the FSM stays in GRANTx indefinitely.
  - A sink stall (m_tready=0) holds the FSM and all outputs stable.
- Single-beat packet (tlast on the first beat): grant lasts exactly one cycle if the sink is ready.
- Counters wrap modulo 2^PCW: from all-ones to 0, with no saturation or flag.
- Reset mid-packet: the grant is dropped immediately and the partial packet is abandoned. The sink sees m_tvalid=0 with no tlast. Reassembly is the upstream/downstream's responsibility.
- Throughput: back-to-back packets cost one idle cycle each. Under continuous contention, grants alternate s1, s2, s1, ...

Test Plan:
- Reset, then s1 sends a 3-beat packet (0x02, 0x04, 0x06, tlast on the 3rd) with m_tready=1 and s2 idle:
  - 1 IDLE cycle, then 3 consecutive m beats with matching data and tlast on 0x06;
  - then busy=0, s1_pkt_cnt=1, s2_tready=0 throughout.
- Both sources present 2-beat packets continuously for 4 packets each:
  - m output order is s1, s2, s1, s2, ... with sel toggling per packet;
  - 1 bubble between packets; both counts end at 4.
- Sink backpressure: during an s2 packet, m_tready=0 for 5 cycles mid-packet:
  - s2_tready=0 and m_tdata is held for those 5 cycles;
  - s1_tready stays 0 even though s1_tvalid=1; no beat is lost or duplicated.
- s1 drops s1_tvalid for 4 cycles mid-packet while s2 is valid:
  - sel stays 0 and s2 is never granted until s1's tlast transfers;
  - s2 is granted on the next arbitration.
- Reset pulse (rst=0 for 1 cycle) after beat 2 of a 5-beat s2 packet:
  - next cycle: busy=0, m_tvalid=0, both counters 0;
  - with both sources then valid, s1 is granted first.
- Counter wrap with PCW=2: five 1-beat s1 packets -> s1_pkt_cnt reads 1,2,3,0,1.

Source files
------------

// File: rtl/axis_pkt_arb_2_1.sv
// Packet-level round-robin arbiter: two AXI-Stream sources onto one sink.
// The grant is held from the first beat through tlast, so packets never interleave.
module axis_pkt_arb_2_1 #(
  parameter int unsigned DW  = 8,
  parameter int unsigned PCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  s1_tdata,
  input  logic           s1_tvalid,
  input  logic           s1_tlast,
  output logic           s1_tready,
  input  logic [DW-1:0]  s2_tdata,
  input  logic           s2_tvalid,
  input  logic           s2_tlast,
  output logic           s2_tready,
  output logic [DW-1:0]  m_tdata,
  output logic           m_tvalid,
  output logic           m_tlast,
  input  logic           m_tready,
  output logic           sel,
  output logic           busy,
  output logic [PCW-1:0] s1_pkt_cnt,
  output logic [PCW-1:0] s2_pkt_cnt
);

  typedef enum logic [1:0] {StIdle, StGrant1, StGrant2} state_e;

  state_e         state_q, state_d;
  logic           last_q, last_d;
  logic [PCW-1:0] s1_cnt_q, s1_cnt_d;
  logic [PCW-1:0] s2_cnt_q, s2_cnt_d;
  logic           xfer;

  // Pure pass-through datapath steered by the current grant.
  always_comb begin
    m_tdata   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s1_tready = 1'b0;
    s2_tready = 1'b0;
    unique case (state_q)
      StGrant1: begin
        m_tdata   = s1_tdata;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
      end
      StGrant2: begin
        m_tdata   = s2_tdata;
        m_tvalid  = s2_tvalid;
        m_tlast   = s2_tlast;
        s2_tready = m_tready;
      end
      default: ;
    endcase
  end

  assign xfer = m_tvalid & m_tready;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    s1_cnt_d = s1_cnt_q;
    s2_cnt_d = s2_cnt_q;
    unique case (state_q)
      StIdle: begin
        // On contention, favour the source that did not finish the previous packet.
        if (s1_tvalid && s2_tvalid) begin
          state_d = last_q ? StGrant1 : StGrant2;
        end else if (s1_tvalid) begin
          state_d = StGrant1;
        end else if (s2_tvalid) begin
          state_d = StGrant2;
        end
      end
      StGrant1: begin
        if (xfer && m_tlast) begin
          s1_cnt_d = s1_cnt_q + PCW'(1);
          last_d   = 1'b0;
          state_d  = StIdle;
        end
      end
      StGrant2: begin
        if (xfer && m_tlast) begin
          s2_cnt_d = s2_cnt_q + PCW'(1);
          last_d   = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      s1_cnt_q <= '0;
      s2_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      s1_cnt_q <= s1_cnt_d;
      s2_cnt_q <= s2_cnt_d;
    end
  end

  assign sel        = (state_q == StGrant2);
  assign busy       = (state_q != StIdle);
  assign s1_pkt_cnt = s1_cnt_q;
  assign s2_pkt_cnt = s2_cnt_q;

endmodule

// File: tb/tb_axis_pkt_arb_2_1.sv
// Randomized bench for axis_pkt_arb_2_1 against a packet-queue reference model.
// A second instance with 2-bit counters shares the stimulus to exercise counter wrap.
module tb_axis_pkt_arb_2_1;

  logic       clk;
  logic       rst;
  logic [7:0] s1_tdata, s2_tdata;
  logic       s1_tvalid, s1_tlast, s2_tvalid, s2_tlast, m_tready;
  logic       s1_tready, s2_tready, m_tvalid, m_tlast, sel, busy;
  logic [7:0] m_tdata;
  logic [15:0] s1_pkt_cnt, s2_pkt_cnt;

  logic       w_s1_tready, w_s2_tready, w_m_tvalid, w_m_tlast, w_sel, w_busy;
  logic [7:0] w_m_tdata;
  logic [1:0] w_s1_pkt_cnt, w_s2_pkt_cnt;

  axis_pkt_arb_2_1 #(.DW(8), .PCW(16)) u_dut (
    .clk(clk), .rst(rst),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(s2_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .sel(sel), .busy(busy), .s1_pkt_cnt(s1_pkt_cnt), .s2_pkt_cnt(s2_pkt_cnt)
  );

  axis_pkt_arb_2_1 #(.DW(8), .PCW(2)) u_dut_wrap (
    .clk(clk), .rst(rst),
    .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(w_s1_tready),
    .s2_tdata(s2_tdata), .s2_tvalid(s2_tvalid), .s2_tlast(s2_tlast), .s2_tready(w_s2_tready),
    .m_tdata(w_m_tdata), .m_tvalid(w_m_tvalid), .m_tlast(w_m_tlast), .m_tready(m_tready),
    .sel(w_sel), .busy(w_busy), .s1_pkt_cnt(w_s1_pkt_cnt), .s2_pkt_cnt(w_s2_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: who owns the sink, who finished last, packets done per source.
  // Each source's pending beats live in a queue as {last, data}.
  int          owner;   // 0 none, 1 s1, 2 s2
  int          rr_last; // 1 -> s1 wins next tie, 2 -> s2 wins next tie
  int unsigned cnt1, cnt2;
  logic [8:0]  q1[$];
  logic [8:0]  q2[$];
  logic        acc1, acc2, flush;
  int          p1, p2, pr, prst;

  task automatic refill(input int s);
    int len;
    logic [8:0] b;
    len = $urandom_range(1, 4);
    for (int i = 0; i < len; i++) begin
      b = {(i == len - 1), 8'($urandom)};
      if (s == 1) q1.push_back(b);
      else        q2.push_back(b);
    end
  endtask

  task automatic check_outputs();
    logic       exp_valid;
    logic [8:0] fr;
    exp_valid = (owner == 1) ? s1_tvalid : (owner == 2) ? s2_tvalid : 1'b0;
    check_eq("busy", 32'(busy), 32'(owner != 0));
    if (owner != 0) check_eq("sel", 32'(sel), 32'(owner == 2));
    check_eq("m_tvalid", 32'(m_tvalid), 32'(exp_valid));
    check_eq("s1_tready", 32'(s1_tready), 32'(owner == 1 && m_tready));
    check_eq("s2_tready", 32'(s2_tready), 32'(owner == 2 && m_tready));
    if (exp_valid) begin
      fr = (owner == 1) ? q1[0] : q2[0];
      check_eq("m_tdata", 32'(m_tdata), 32'(fr[7:0]));
      check_eq("m_tlast", 32'(m_tlast), 32'(fr[8]));
    end else if (owner == 0) begin
      check_eq("idle_tdata", 32'(m_tdata), 32'd0);
      check_eq("idle_tlast", 32'(m_tlast), 32'd0);
    end
    check_eq("s1_pkt_cnt", 32'(s1_pkt_cnt), cnt1 % 65536);
    check_eq("s2_pkt_cnt", 32'(s2_pkt_cnt), cnt2 % 65536);
    check_eq("wrap_s1_cnt", 32'(w_s1_pkt_cnt), cnt1 % 4);
    check_eq("wrap_s2_cnt", 32'(w_s2_pkt_cnt), cnt2 % 4);
  endtask

  // Advance the model with the inputs the DUT sampled on this edge.
  task automatic update_model();
    logic [8:0] fr;
    acc1 = 1'b0;
    acc2 = 1'b0;
    if (!rst) begin
      owner = 0; rr_last = 1; cnt1 = 0; cnt2 = 0; flush = 1'b1;
    end else if (owner == 0) begin
      if (s1_tvalid && s2_tvalid) owner = rr_last;
      else if (s1_tvalid)         owner = 1;
      else if (s2_tvalid)         owner = 2;
    end else if (owner == 1 && s1_tvalid && m_tready) begin
      acc1 = 1'b1;
      fr = q1.pop_front();
      if (fr[8]) begin cnt1++; rr_last = 2; owner = 0; end
    end else if (owner == 2 && s2_tvalid && m_tready) begin
      acc2 = 1'b1;
      fr = q2.pop_front();
      if (fr[8]) begin cnt2++; rr_last = 1; owner = 0; end
    end
  endtask

  // Sources keep a presented beat stable until accepted; a reset abandons queued beats.
  task automatic gen_inputs();
    if (flush) begin
      q1.delete(); q2.delete();
      s1_tvalid = 1'b0; s2_tvalid = 1'b0;
      flush = 1'b0;
    end
    if (q1.size() == 0) refill(1);
    if (q2.size() == 0) refill(2);
    if (!(s1_tvalid && !acc1)) s1_tvalid = ($urandom_range(0, 99) < p1);
    if (!(s2_tvalid && !acc2)) s2_tvalid = ($urandom_range(0, 99) < p2);
    s1_tdata = s1_tvalid ? q1[0][7:0] : 8'($urandom);
    s1_tlast = s1_tvalid ? q1[0][8]   : 1'($urandom);
    s2_tdata = s2_tvalid ? q2[0][7:0] : 8'($urandom);
    s2_tlast = s2_tvalid ? q2[0][8]   : 1'($urandom);
    m_tready = ($urandom_range(0, 99) < pr);
    rst      = !($urandom_range(0, 999) < prst);
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    update_model();
    #1;
    gen_inputs();
  endtask

  task automatic run(input int n, input int a, input int b, input int r, input int rs);
    p1 = a; p2 = b; pr = r; prst = rs;
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b0;
    s1_tvalid = 1'b0; s2_tvalid = 1'b0; s1_tlast = 1'b0; s2_tlast = 1'b0;
    s1_tdata = '0; s2_tdata = '0; m_tready = 1'b0;
    acc1 = 1'b0; acc2 = 1'b0;
    p1 = 0; p2 = 0; pr = 100; prst = 0;
    repeat (2) @(posedge clk);
    owner = 0; rr_last = 1; cnt1 = 0; cnt2 = 0; flush = 1'b1;
    #1;
    gen_inputs();
    run(4, 0, 0, 100, 0);      // reset state held with idle sources
    run(200, 100, 0, 100, 0);  // s1 alone, sink always ready
    run(300, 100, 100, 100, 0);// continuous contention: strict alternation
    run(400, 80, 80, 50, 0);   // contention with sink backpressure
    run(400, 40, 95, 30, 0);   // bursty s1 valid gaps mid-packet
    run(600, 70, 70, 80, 15);  // occasional reset pulses mid-packet
    run(300, 90, 90, 90, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
